// File: rtl/md_ctrl_if.sv
// md_ctrl_if: signal bundle between the E/D pipeline stages and the
// multiply/divide sequencer.
//   master (pipeline side): drives start, op, A, B, md_use_D;
//                           observes busy, md_stall, HI, LO
//   slave  (md_ctrl side) : the opposite directions
interface md_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B, md_use_D,
    input  busy, md_stall, HI, LO
  );

  modport slave (
    input  start, op, A, B, md_use_D,
    output busy, md_stall, HI, LO
  );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO owner for the pipelined MIPS core. mult/multu/div/divu
// are computed at launch into shadow registers and committed to HI/LO
// after a fixed latency; mthi/mtlo write HI/LO directly at launch.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   md     : md_ctrl_if.slave (start/op/A/B/md_use_D in,
//            busy/md_stall/HI/LO out)
//
// state | meaning
// IDLE  | accepts launches; mthi/mtlo write here
// RUN   | result held in hi_n/lo_n, cnt counts down to the commit edge
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  md_ctrl_if.slave md
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, b_zero;
  logic [31:0] dvd, dvs, quo_u, rem_u, quo, rem;

  // Signed division is done on magnitudes so the -2^31 / -1 case needs
  // no special handling: 0x80000000 / 1 is simply 0x80000000.
  always_comb begin
    prod_s     = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    prod_u     = {32'd0, md.A} * {32'd0, md.B};
    div_signed = ~md.op[0];
    b_zero     = (md.B == 32'd0);
    dvd        = (div_signed && md.A[31]) ? (~md.A + 32'd1) : md.A;
    dvs        = (div_signed && md.B[31]) ? (~md.B + 32'd1) : md.B;
    if (b_zero) dvs = 32'd1;
    quo_u      = dvd / dvs;
    rem_u      = dvd % dvs;
    quo        = (div_signed && (md.A[31] ^ md.B[31])) ? (~quo_u + 32'd1) : quo_u;
    rem        = (div_signed && md.A[31]) ? (~rem_u + 32'd1) : rem_u;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md.op)
            3'd0: begin
              {hi_n_d, lo_n_d} = prod_s;
              cnt_d            = MULT_LOAD;
              state_d          = RUN;
            end
            3'd1: begin
              {hi_n_d, lo_n_d} = prod_u;
              cnt_d            = MULT_LOAD;
              state_d          = RUN;
            end
            3'd2, 3'd3: begin
              // divide by zero: shadow the current HI/LO so the commit
              // is a no-op while the latency is still honoured
              hi_n_d  = b_zero ? hi_q : rem;
              lo_n_d  = b_zero ? lo_q : quo;
              cnt_d   = DIV_LOAD;
              state_d = RUN;
            end
            3'd4:    hi_d = md.A;
            3'd5:    lo_d = md.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) begin
          hi_d    = hi_n_q;
          lo_d    = lo_n_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy     = (state_q == RUN);
  assign md.md_stall = md.md_use_D & (md.start | md.busy);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and randomized checks of md_ctrl against a
// behavioural HI/LO model using 64-bit arithmetic.
module tb_md_ctrl;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  md_ctrl_if md();

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected HI/LO after an op completes, from plain 64-bit arithmetic.
  function automatic void model_result(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b,
                                       output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    hi = m_hi;
    lo = m_lo;
    case (op)
      3'd0: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd1: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd2: if (b != 32'd0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
      end
      3'd3: if (b != 32'd0) begin
        lo = a / b;
        hi = a % b;
      end
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d, input bit inject);
    logic [31:0] e_hi, e_lo;
    int          n, n_exp;
    @(negedge clk);
    md.start    = 1'b1;
    md.op       = op;
    md.A        = a;
    md.B        = b;
    md.md_use_D = use_d;
    #1 chk("stall_launch", 32'(md.md_stall), 32'(use_d));
    model_result(op, a, b, e_hi, e_lo);
    @(negedge clk);
    md.start = 1'b0;
    md.op    = 3'd7;
    #1;
    if (op == 3'd4) m_hi = a;
    else if (op == 3'd5) m_lo = a;
    if (op > 3'd3) begin
      chk("busy_single", 32'(md.busy), 32'd0);
      chk("stall_single", 32'(md.md_stall), 32'd0);
      chk("hi_single", md.HI, m_hi);
      chk("lo_single", md.LO, m_lo);
    end else begin
      n_exp = (op < 3'd2) ? 5 : 10;
      n     = 0;
      while (md.busy === 1'b1 && n < 40) begin
        chk("stall_run", 32'(md.md_stall), 32'(use_d));
        chk("hi_hold", md.HI, m_hi);
        chk("lo_hold", md.LO, m_lo);
        @(negedge clk);
        md.start = inject && (n == 0);
        if (md.start) begin
          md.op = 3'd4;
          md.A  = 32'hDEAD_BEEF;
        end
        n++;
        #1;
      end
      md.start = 1'b0;
      m_hi     = e_hi;
      m_lo     = e_lo;
      chk("busy_len", n, n_exp);
      chk("stall_after", 32'(md.md_stall), 32'd0);
      chk("hi_commit", md.HI, m_hi);
      chk("lo_commit", md.LO, m_lo);
    end
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(32'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] r_op;
    md.start    = 1'b0;
    md.op       = 3'd7;
    md.A        = 32'd0;
    md.B        = 32'd0;
    md.md_use_D = 1'b1;
    #3;
    chk("rst_busy", 32'(md.busy), 32'd0);
    chk("rst_hi", md.HI, 32'd0);
    chk("rst_lo", md.LO, 32'd0);
    chk("rst_stall_idle", 32'(md.md_stall), 32'd0);
    md.start = 1'b1;
    #1 chk("rst_stall_start", 32'(md.md_stall), 32'd1);
    md.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    do_op(3'd0, 32'h0000_1234, 32'h8765_4321, 1'b0, 1'b0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    do_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    do_op(3'd4, 32'h11, 32'd0, 1'b0, 1'b0);
    do_op(3'd5, 32'h22, 32'd0, 1'b0, 1'b0);
    do_op(3'd2, 32'd5, 32'd0, 1'b1, 1'b0);
    chk("div0_hi", md.HI, 32'h11);
    chk("div0_lo", md.LO, 32'h22);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_lo", md.LO, 32'h8000_0000);
    chk("ovf_hi", md.HI, 32'd0);

    // mthi then mtlo on consecutive cycles
    @(negedge clk);
    md.start    = 1'b1;
    md.op       = 3'd4;
    md.A        = 32'hABCD;
    md.md_use_D = 1'b0;
    @(negedge clk);
    chk("mthi_hi", md.HI, 32'hABCD);
    chk("mthi_busy", 32'(md.busy), 32'd0);
    md.op = 3'd5;
    md.A  = 32'h1234;
    @(negedge clk);
    md.start = 1'b0;
    chk("mtlo_lo", md.LO, 32'h1234);
    chk("mtlo_hi", md.HI, 32'hABCD);
    chk("mtlo_busy", 32'(md.busy), 32'd0);
    m_hi = 32'hABCD;
    m_lo = 32'h1234;

    // start during RUN must be ignored
    do_op(3'd1, 32'd6, 32'd7, 1'b1, 1'b1);

    // asynchronous reset in the middle of mult 3x4
    do_op(3'd4, 32'h55, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    md.start    = 1'b1;
    md.op       = 3'd0;
    md.A        = 32'd3;
    md.B        = 32'd4;
    md.md_use_D = 1'b1;
    @(negedge clk);
    md.start = 1'b0;
    @(negedge clk);
    #1 chk("mid_busy", 32'(md.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(md.busy), 32'd0);
    chk("arst_hi", md.HI, 32'd0);
    chk("arst_lo", md.LO, 32'd0);
    chk("arst_stall", 32'(md.md_stall), 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_hi", md.HI, 32'd0);
    chk("post_rst_lo", md.LO, 32'd0);
    chk("post_rst_busy", 32'(md.busy), 32'd0);

    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      do_op(r_op, pick($urandom_range(0, 5)), pick($urandom_range(0, 5)) & {32{($urandom_range(0, 5) != 0)}},
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      chk("rand_hi", md.HI, m_hi);
      chk("rand_lo", md.LO, m_lo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the pipelined MIPS CPU. It owns the HI/LO register pair and runs mult, multu, div and divu as fixed-latency multi-cycle operations launched from the E stage, and executes mthi/mtlo as single-cycle writes. It drives a busy flag and a D-stage stall request, which the hazard unit ORs into its existing stall, so that no later HI/LO instruction issues while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy duration for mult/multu; legal range 1–15.
- DIV_CYCLES, default 10: busy duration for div/divu; legal range 1–15.

Ports:
- clk  input  1  the single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  E-stage launch strobe, one cycle per instruction.
- op  input  3  0 = mult, 1 = multu, 2 = div, 3 = divu, 4 = mthi, 5 = mtlo; 6 and 7 are no-op.
- A  input  32  forwarded rs value (E stage).
- B  input  32  forwarded rt value (E stage).
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in flight.
- md_stall  output  1  stall request to the hazard unit.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

## Operation
- States: IDLE and RUN, plus a 4-bit down-counter cnt and 32-bit shadow registers hi_n and lo_n.
- IDLE, start=1, op in 0..3:
  - Compute the result combinationally from A and B, latch it into hi_n and lo_n.
  - Load cnt with (MULT_CYCLES or DIV_CYCLES) − 1 and go to RUN.
- IDLE, start=1, op=4: HI←A on the same edge. op=5: LO←A. State stays IDLE and busy stays 0.
- IDLE, start=1, op 6..7: ignored.
- RUN: cnt decrements each edge. On the edge where cnt==0, HI←hi_n, LO←lo_n, and the state returns to IDLE.
- start during RUN is ignored. The hazard unit guarantees this never happens; the verification bench asserts it.
- busy = (state==RUN), driven from a register.
- md_stall = md_use_D & (start | busy), combinational.
- Arithmetic:
  - mult: signed 64-bit product. multu: unsigned 64-bit product. In both, {HI,LO} = product.
  - div/divu: LO = quotient, HI = remainder. The signed quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - Signed −2^31 / −1 gives LO=0x80000000, HI=0.
  - Divide by zero (B==0): the operation still holds busy for DIV_CYCLES, but HI and LO are left unchanged at completion.
- HI and LO are visible only after commit. mfhi/mflo read the outputs directly, with no forwarding from the shadow registers.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, busy=0, HI=0, LO=0, hi_n=0, lo_n=0. md_stall then equals md_use_D & start.
- Reset asserted mid-operation aborts it; the pending result is discarded.
- Launch at edge t0 (start=1 sampled):
  - busy=1 during cycles t0+1 through t0+N, where N is the op latency.
  - The edge ending cycle t0+N clears busy and updates HI/LO together.
  - With N=1, busy is high for exactly one cycle.
- mthi/mtlo: HI or LO changes at the launch edge and busy never rises.
- md_stall rises in the launch cycle itself (through start), so a dependent mfhi in D is held from the first cycle. It falls in the cycle after commit.
- Back-to-back: a new start is accepted in the first cycle after busy falls.

## Test plan
- Reset: hold rst_n=0 mid-RUN after mult 3×4 → busy=0, HI=0, LO=0 immediately, asynchronous to clk. After release, HI/LO stay 0.
- mult A=0xFFFFFFFF, B=2 (signed −1×2):
  - busy high for exactly 5 cycles.
  - At the falling edge of busy, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands gives HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2: busy high for 10 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu A=7, B=2 gives LO=3, HI=1.
- Divide by zero: first HI=0x11, LO=0x22 via mthi/mtlo, then div A=5, B=0 → busy high for 10 cycles, HI=0x11, LO=0x22 unchanged. Also div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Stall: start mult with md_use_D=1 held → md_stall=1 from the launch cycle through the last busy cycle, then 0. With md_use_D=0, md_stall stays 0 throughout while busy still rises.
- mthi A=0xABCD then mtlo A=0x1234 on consecutive cycles → HI=0xABCD after the first edge, LO=0x1234 after the second, busy=0 throughout. A start during RUN is ignored and the original result commits.
